fft_frame_reader: RTL
=====================

FFT_FRAME_READER -- requirements
Module: fft_frame_reader

Interface
REQ-001 Parameter FRAME_LEN, default 8: output samples per FFT frame; legal range 2..16.
REQ-002 Parameter DATA_W, default 4: width of each FFT output sample.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 fft_data  input  DATA_W  FFT output sample stream; one sample per cycle.
REQ-006 fft_idx_zero  input  1  high on the cycle fft_data carries sample index 0 of a frame.
REQ-007 frame_data  output  FRAME_LEN*DATA_W  captured frame; sample k in bits [k*DATA_W +: DATA_W].
REQ-008 frame_valid  output  1  frame_data holds a complete frame.
REQ-009 frame_ready  input  1  consumer accepts the frame when frame_valid and frame_ready are both high.
REQ-010 sync_lost  output  1  sticky: fft_idx_zero seen before a frame completed.
REQ-011 overrun  output  1  sticky: a new frame started while a held frame was unaccepted.

Function
REQ-012 The block SHALL implement three states: SYNC, CAPTURE and HOLD.
REQ-013 SYNC: the block SHALL ignore fft_data until fft_idx_zero=1; on that cycle it SHALL store fft_data into slot 0, set count=1 and enter CAPTURE.
REQ-014 CAPTURE: each cycle the block SHALL store fft_data into slot count and increment count.
REQ-015 CAPTURE: if fft_idx_zero=1 with count!=0, the block SHALL set sync_lost, store fft_data into slot 0, set count=1 and stay in CAPTURE (resync, partial frame discarded).
REQ-016 CAPTURE: on the cycle slot FRAME_LEN-1 is stored, the block SHALL enter HOLD, with frame_valid=1 from the next cycle.
REQ-017 Latency: frame_valid SHALL rise exactly 1 cycle after the sample at index FRAME_LEN-1 is sampled, so FRAME_LEN cycles after the fft_idx_zero cycle.
REQ-018 HOLD: frame_data and frame_valid SHALL stay stable until the handshake; slots SHALL not be written.
REQ-019 HOLD with handshake and fft_idx_zero=0: the block SHALL clear frame_valid next cycle and enter SYNC.
REQ-020 HOLD with handshake and fft_idx_zero=1 on the same cycle: the block SHALL store fft_data into slot 0, set count=1 and enter CAPTURE; no overrun.
REQ-021 HOLD with fft_idx_zero=1 and no handshake: the block SHALL set overrun, keep the held frame intact and drop the incoming frame (stay in HOLD).
REQ-022 frame_ready while frame_valid=0 SHALL have no effect.
REQ-023 sync_lost and overrun SHALL stay set until rst; they never clear on their own.
REQ-024 count SHALL be wide enough for FRAME_LEN and SHALL never address a slot >= FRAME_LEN.

Reset
REQ-025 While rst=1 at a clock edge: state=SYNC, count=0, frame_valid=0, sync_lost=0, overrun=0, frame_data=0.
REQ-026 rst SHALL take priority over all inputs, including mid-CAPTURE or HOLD; the partial or held frame SHALL be discarded.
REQ-027 The first valid frame after reset SHALL require a fresh fft_idx_zero pulse.

Verification
REQ-028 FRAME_LEN=8; idx_zero at cycle 0, data 1..8 on cycles 0..7, ready=1 -> frame_valid high at cycle 8 only, frame_data=0x87654321, flags 0.
REQ-029 Data 0xF with no idx_zero for 20 cycles, then a frame 0..7 -> exactly one frame, frame_data=0x76543210.
REQ-030 idx_zero at cycle 0 and again at cycle 3, data=cycle number -> sync_lost=1; frame built from cycles 3..10, frame_data=0xA9876543.
REQ-031 Frame A held with ready=0, frame B idx_zero arrives -> overrun=1, frame_data stays A; then ready=1 -> A accepted, B never presented.
REQ-032 ready=1 on the exact cycle of frame B's idx_zero -> A accepted, B captured back-to-back, B valid 8 cycles later, overrun=0.
REQ-033 rst pulsed at count=5 in CAPTURE -> all outputs 0 next cycle; no frame until the next idx_zero.

Source files
------------

// File: rtl/fft_frame_reader.sv
// Collects one FFT output frame (FRAME_LEN samples starting at index 0) into a
// parallel register bank and holds it until the consumer accepts it.
module fft_frame_reader #(
   parameter int FRAME_LEN = 8,
   parameter int DATA_W    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_W-1:0]             fft_data,
   input  logic                          fft_idx_zero,
   output logic [FRAME_LEN*DATA_W-1:0]   frame_data,
   output logic                          frame_valid,
   input  logic                          frame_ready,
   output logic                          sync_lost,
   output logic                          overrun
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_CAPTURE,
      ST_HOLD
   } state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [DATA_W-1:0]  slot_reg [FRAME_LEN];

   logic handshake;
   logic load_first;
   logic store_next;

   assign handshake = frame_valid & frame_ready;

   // load_first: this cycle's sample becomes slot 0 of a new frame.
   always_comb begin
      load_first = 1'b0;
      store_next = 1'b0;
      case (state_reg)
         ST_SYNC:    load_first = fft_idx_zero;
         ST_CAPTURE: begin
            load_first = fft_idx_zero;
            store_next = ~fft_idx_zero;
         end
         ST_HOLD:    load_first = fft_idx_zero & handshake;
         default:    load_first = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_SYNC;
         count_reg   <= '0;
         frame_valid <= 1'b0;
         sync_lost   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         case (state_reg)
            ST_SYNC: begin
               if (fft_idx_zero) begin
                  count_reg <= CNT_ONE;
                  state_reg <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (fft_idx_zero) begin
                  // Early index 0: drop the partial frame and restart on this sample.
                  sync_lost <= 1'b1;
                  count_reg <= CNT_ONE;
               end else if (count_reg == CNT_LAST) begin
                  count_reg   <= '0;
                  frame_valid <= 1'b1;
                  state_reg   <= ST_HOLD;
               end else begin
                  count_reg <= count_reg + CNT_ONE;
               end
            end
            ST_HOLD: begin
               if (handshake) begin
                  frame_valid <= 1'b0;
                  if (fft_idx_zero) begin
                     count_reg <= CNT_ONE;
                     state_reg <= ST_CAPTURE;
                  end else begin
                     state_reg <= ST_SYNC;
                  end
               end else if (fft_idx_zero) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               state_reg <= ST_SYNC;
               count_reg <= '0;
            end
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < FRAME_LEN; gi++) begin : g_slot
         always_ff @(posedge clk) begin
            if (rst) begin
               slot_reg[gi] <= '0;
            end else if ((load_first && gi == 0) ||
                         (store_next && count_reg == CNT_W'(gi))) begin
               slot_reg[gi] <= fft_data;
            end
         end
         assign frame_data[gi*DATA_W +: DATA_W] = slot_reg[gi];
      end
   endgenerate

endmodule
